// File: rtl/prbs_ber_checker.sv
// ---------------------------------------------------------------------------
// prbs_ber_checker
//
// Purpose
//   Terminal sink for the slicer byte stream (LSB-first bytes, in_last marks
//   the final byte of a frame). It self-synchronises a PRBS LFSR to the
//   received bits, then free-runs the LFSR and compares every byte against
//   the predicted sequence. It counts bit errors, checked bits, frames and
//   lock losses, and reports lock status.
//
// Parameters
//   PRBS_ORDER     15 -> x^15+x^14+1, 7 -> x^7+x^6+1
//   LOCK_BYTES     consecutive clean bytes in SEARCH needed to lock (1..255)
//   UNLOCK_BYTES   consecutive bad bytes in LOCKED that drop lock (1..255)
//   BAD_BIT_THRESH a byte is bad when its error popcount >= this (1..8)
//
// Ports
//   clk_bb         in   baseband clock
//   rst_n          in   asynchronous active-low reset
//   in_valid       in   input byte valid
//   in_ready       out  input ready (equals enable)
//   in_data[7:0]   in   received byte, bit0 is the earliest bit
//   in_last        in   last byte of a frame
//   enable         in   checker enable; low freezes all state
//   clear          in   one-cycle pulse: zero counters, force SEARCH
//   locked         out  high while in LOCKED
//   bit_err_cnt    out  bit errors seen while LOCKED (saturating)
//   bit_chk_cnt    out  bits checked while LOCKED (saturating)
//   frame_cnt      out  in_last bytes accepted while LOCKED (saturating)
//   lock_loss_cnt  out  LOCKED -> SEARCH transitions (saturating)
//
// Optional feature (macro PRBS_CHK_FRAME_STATS_EN)
//   frame_err_cnt[15:0] out  bit errors of the frame just completed
//   frame_err_valid     out  one-cycle pulse when frame_err_cnt updates
// ---------------------------------------------------------------------------
module prbs_ber_checker #(
  parameter int PRBS_ORDER     = 15,
  parameter int LOCK_BYTES     = 4,
  parameter int UNLOCK_BYTES   = 8,
  parameter int BAD_BIT_THRESH = 3
) (
  input  logic        clk_bb,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  in_data,
  input  logic        in_last,
  input  logic        enable,
  input  logic        clear,
  output logic        locked,
  output logic [31:0] bit_err_cnt,
  output logic [31:0] bit_chk_cnt,
  output logic [15:0] frame_cnt,
  output logic [15:0] lock_loss_cnt
`ifdef PRBS_CHK_FRAME_STATS_EN
  ,
  output logic [15:0] frame_err_cnt,
  output logic        frame_err_valid
`endif
);

  // Elaboration-time parameter checks
  if (PRBS_ORDER != 15 && PRBS_ORDER != 7) begin : g_bad_order
    $error("prbs_ber_checker: PRBS_ORDER must be 15 or 7");
  end
  if (LOCK_BYTES < 1 || LOCK_BYTES > 255) begin : g_bad_lock
    $error("prbs_ber_checker: LOCK_BYTES must be 1..255");
  end
  if (UNLOCK_BYTES < 1 || UNLOCK_BYTES > 255) begin : g_bad_unlock
    $error("prbs_ber_checker: UNLOCK_BYTES must be 1..255");
  end
  if (BAD_BIT_THRESH < 1 || BAD_BIT_THRESH > 8) begin : g_bad_thresh
    $error("prbs_ber_checker: BAD_BIT_THRESH must be 1..8");
  end

  typedef enum logic {
    ST_SEARCH = 1'b0,
    ST_LOCKED = 1'b1
  } state_t;

  localparam logic [7:0] LOCK_LAST   = 8'(LOCK_BYTES - 1);
  localparam logic [7:0] UNLOCK_LAST = 8'(UNLOCK_BYTES - 1);
  localparam logic [3:0] BAD_THRESH  = 4'(BAD_BIT_THRESH);

  state_t                  state_reg;
  logic                    locked_reg;
  logic [PRBS_ORDER-1:0]   lfsr_reg;
  logic [PRBS_ORDER-1:0]   lfsr_walk;
  logic [PRBS_ORDER-1:0]   lfsr_next;
  logic [7:0]              match_run_reg;
  logic [7:0]              bad_run_reg;
  logic [31:0]             bit_err_cnt_reg;
  logic [31:0]             bit_chk_cnt_reg;
  logic [15:0]             frame_cnt_reg;
  logic [15:0]             lock_loss_cnt_reg;

  logic                    accept;
  logic                    free_run;
  logic                    pb;
  logic                    fb;
  logic [7:0]              pred_byte;
  logic [7:0]              err_vec;
  logic [3:0]              err_bits;

  // 33-bit add then clamp: counters stick at all-ones instead of wrapping
  function automatic logic [31:0] sat_add32(input logic [31:0] a, input logic [31:0] b);
    logic [32:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return sum[32] ? 32'hFFFF_FFFF : sum[31:0];
  endfunction

  function automatic logic [15:0] sat_add16(input logic [15:0] a, input logic [15:0] b);
    logic [16:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return sum[16] ? 16'hFFFF : sum[15:0];
  endfunction

  assign accept   = in_valid && enable;
  assign in_ready = enable;

  // The LFSR free-runs only while locked; in SEARCH (and on a clear, which
  // forces SEARCH) it reloads itself from the received bits.
  assign free_run = (state_reg == ST_LOCKED) && !clear;

  // Eight serial LFSR steps per byte; bit k of the prediction is the
  // feedback of step k.
  always_comb begin
    lfsr_walk = lfsr_reg;
    pred_byte = '0;
    pb        = 1'b0;
    fb        = 1'b0;
    for (int k = 0; k < 8; k++) begin
      pb           = lfsr_walk[PRBS_ORDER-1] ^ lfsr_walk[PRBS_ORDER-2];
      pred_byte[k] = pb;
      fb           = free_run ? pb : in_data[k];
      lfsr_walk    = {lfsr_walk[PRBS_ORDER-2:0], fb};
    end
    lfsr_next = lfsr_walk;
  end

  for (genvar gi = 0; gi < 8; gi++) begin : g_err_vec
    assign err_vec[gi] = pred_byte[gi] ^ in_data[gi];
  end

  always_comb begin
    err_bits = '0;
    for (int k = 0; k < 8; k++) begin
      err_bits = err_bits + {3'b000, err_vec[k]};
    end
  end

  // Lock FSM and statistics
  always_ff @(posedge clk_bb or negedge rst_n) begin
    if (!rst_n) begin
      state_reg         <= ST_SEARCH;
      locked_reg        <= 1'b0;
      lfsr_reg          <= '0;
      match_run_reg     <= '0;
      bad_run_reg       <= '0;
      bit_err_cnt_reg   <= '0;
      bit_chk_cnt_reg   <= '0;
      frame_cnt_reg     <= '0;
      lock_loss_cnt_reg <= '0;
    end else begin
      // The LFSR keeps tracking the stream even on a clearing byte
      if (accept) begin
        lfsr_reg <= lfsr_next;
      end

      if (clear) begin
        state_reg         <= ST_SEARCH;
        locked_reg        <= 1'b0;
        match_run_reg     <= '0;
        bad_run_reg       <= '0;
        bit_err_cnt_reg   <= '0;
        bit_chk_cnt_reg   <= '0;
        frame_cnt_reg     <= '0;
        lock_loss_cnt_reg <= '0;
      end else if (accept) begin
        case (state_reg)
          ST_SEARCH: begin
            // An all-zero state predicts all-zero bytes; never trust it
            if (err_bits == 4'd0 && lfsr_reg != '0) begin
              if (match_run_reg == LOCK_LAST) begin
                state_reg     <= ST_LOCKED;
                locked_reg    <= 1'b1;
                match_run_reg <= '0;
                bad_run_reg   <= '0;
              end else begin
                match_run_reg <= match_run_reg + 8'd1;
              end
            end else begin
              match_run_reg <= '0;
            end
          end
          ST_LOCKED: begin
            // The unlocking byte itself is still counted
            bit_err_cnt_reg <= sat_add32(bit_err_cnt_reg, {28'd0, err_bits});
            bit_chk_cnt_reg <= sat_add32(bit_chk_cnt_reg, 32'd8);
            frame_cnt_reg   <= sat_add16(frame_cnt_reg, {15'd0, in_last});
            if (err_bits >= BAD_THRESH) begin
              if (bad_run_reg == UNLOCK_LAST) begin
                state_reg         <= ST_SEARCH;
                locked_reg        <= 1'b0;
                lock_loss_cnt_reg <= sat_add16(lock_loss_cnt_reg, 16'd1);
                bad_run_reg       <= '0;
                match_run_reg     <= '0;
              end else begin
                bad_run_reg <= bad_run_reg + 8'd1;
              end
            end else begin
              bad_run_reg <= '0;
            end
          end
          default: begin
            state_reg  <= ST_SEARCH;
            locked_reg <= 1'b0;
          end
        endcase
      end
    end
  end

  assign locked        = locked_reg;
  assign bit_err_cnt   = bit_err_cnt_reg;
  assign bit_chk_cnt   = bit_chk_cnt_reg;
  assign frame_cnt     = frame_cnt_reg;
  assign lock_loss_cnt = lock_loss_cnt_reg;

`ifdef PRBS_CHK_FRAME_STATS_EN
  logic [15:0] frame_accum_reg;
  logic [15:0] frame_err_cnt_reg;
  logic        frame_err_valid_reg;
  logic [15:0] frame_err_add;

  // Errors are only attributed to a frame while the checker is locked
  assign frame_err_add = (state_reg == ST_LOCKED) ? {12'd0, err_bits} : 16'd0;

  always_ff @(posedge clk_bb or negedge rst_n) begin
    if (!rst_n) begin
      frame_accum_reg     <= '0;
      frame_err_cnt_reg   <= '0;
      frame_err_valid_reg <= 1'b0;
    end else begin
      frame_err_valid_reg <= 1'b0;
      if (clear) begin
        frame_accum_reg   <= '0;
        frame_err_cnt_reg <= '0;
      end else if (accept) begin
        if (in_last) begin
          frame_err_cnt_reg   <= sat_add16(frame_accum_reg, frame_err_add);
          frame_err_valid_reg <= 1'b1;
          frame_accum_reg     <= '0;
        end else begin
          frame_accum_reg <= sat_add16(frame_accum_reg, frame_err_add);
        end
      end
    end
  end

  assign frame_err_cnt   = frame_err_cnt_reg;
  assign frame_err_valid = frame_err_valid_reg;
`endif

endmodule
